// File: rtl/gbf_flgwei_fifo_ctrl_pkg.sv
// Shared types and constants for the flag/weight global-buffer FIFO controller.
package gbf_ctrl_pkg;

    localparam int   SKID_DEPTH = 2;
    localparam logic PRI_WR_RST = 1'b1;

    typedef enum logic {
        PRI_RD = 1'b0,
        PRI_WR = 1'b1
    } pri_e;

    // level must hold 0..2**depth_bit inclusive, hence one extra bit.
    function automatic int level_w(input int depth_bit);
        return depth_bit + 1;
    endfunction

endpackage

// File: rtl/gbf_flgwei_fifo_ctrl_if.sv
// Loader stream, PE-side stream and single-port SRAM bus of the FIFO controller.
interface gbf_flgwei_fifo_ctrl_if #(
    parameter int SRAM_DEPTH_BIT = 6,
    parameter int SRAM_WIDTH     = 28
);
    import gbf_ctrl_pkg::*;

    logic                                 wr_valid;
    logic                                 wr_ready;
    logic [SRAM_WIDTH-1:0]                wr_data;
    logic                                 rd_valid;
    logic                                 rd_ready;
    logic [SRAM_WIDTH-1:0]                rd_data;
    logic [level_w(SRAM_DEPTH_BIT)-1:0]   level;
    logic [SRAM_DEPTH_BIT-1:0]            sram_addr_w;
    logic [SRAM_DEPTH_BIT-1:0]            sram_addr_r;
    logic                                 sram_write_en;
    logic                                 sram_read_en;
    logic [SRAM_WIDTH-1:0]                sram_data_in;
    logic [SRAM_WIDTH-1:0]                sram_data_out;

    modport master (
        input  wr_valid, wr_data, rd_ready, sram_data_out,
        output wr_ready, rd_valid, rd_data, level,
               sram_addr_w, sram_addr_r, sram_write_en, sram_read_en, sram_data_in
    );

    modport slave (
        output wr_valid, wr_data, rd_ready, sram_data_out,
        input  wr_ready, rd_valid, rd_data, level,
               sram_addr_w, sram_addr_r, sram_write_en, sram_read_en, sram_data_in
    );

endinterface

// File: rtl/gbf_flgwei_fifo_ctrl_skid.sv
// Two-entry output skid buffer catching SRAM read returns ahead of the consumer.
module gbf_rd_skid
    import gbf_ctrl_pkg::*;
#(
    parameter int WIDTH = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic             head;
    logic             tail;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (occ != 2'd0);
        do_push = push && ((occ != 2'd2) || do_pop);
        // With two slots the tail is the head slot when occ is even, the other one when odd.
        tail    = head ^ occ[0];
    end

    assign head_data = mem[head];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= 1'b0;
            occ  <= 2'd0;
        end else if (flush) begin
            head <= 1'b0;
            occ  <= 2'd0;
        end else begin
            if (do_pop) begin
                head <= ~head;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/gbf_flgwei_fifo_ctrl.sv
// Runs the single-port flag/weight GBF SRAM as a circular FIFO with write/read arbitration.
module gbf_flgwei_fifo_ctrl
    import gbf_ctrl_pkg::*;
#(
    parameter int SRAM_DEPTH_BIT = 6,
    parameter int SRAM_WIDTH     = 28
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    gbf_flgwei_fifo_ctrl_if.master  bus
);

    localparam int LW    = level_w(SRAM_DEPTH_BIT);
    localparam int DEPTH = 1 << SRAM_DEPTH_BIT;

    logic [SRAM_DEPTH_BIT-1:0] wr_ptr;
    logic [SRAM_DEPTH_BIT-1:0] rd_ptr;
    logic [LW-1:0]             count;
    logic                      rd_pend;
    pri_e                      pri;
    pri_e                      pri_next;

    logic [1:0]                skid_occ;
    logic [SRAM_WIDTH-1:0]     skid_head;

    logic full;
    logic empty;
    logic rd_want;
    logic wr_ready;
    logic wr_go;
    logic rd_go;
    logic conflict;
    logic rd_valid;
    logic pop;

    always_comb begin
        full     = (count == LW'(DEPTH));
        empty    = (count == '0);
        // Outstanding read plus buffered words must leave room for the return.
        rd_want  = !empty && (({1'b0, skid_occ} + {2'b00, rd_pend}) < 3'd2);
        wr_ready = !full && !(rd_want && (pri == PRI_RD));
        wr_go    = bus.wr_valid && wr_ready && !flush;
        rd_go    = rd_want && !wr_go && !flush;
        conflict = bus.wr_valid && rd_want && !full;
        rd_valid = (skid_occ != 2'd0);
        pop      = rd_valid && bus.rd_ready;
    end

    always_comb begin
        pri_next = pri;
        if (flush) begin
            pri_next = PRI_WR_RST ? PRI_WR : PRI_RD;
        end else if (conflict) begin
            pri_next = (pri == PRI_WR) ? PRI_RD : PRI_WR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri <= PRI_WR_RST ? PRI_WR : PRI_RD;
        end else begin
            pri <= pri_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_pend <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_go;
            if (wr_go) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + LW'(1);
            end else if (rd_go) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - LW'(1);
            end
        end
    end

    gbf_rd_skid #(
        .WIDTH (SRAM_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (rd_pend),
        .push_data (bus.sram_data_out),
        .pop       (pop),
        .head_data (skid_head),
        .occ       (skid_occ)
    );

    assign bus.wr_ready      = wr_ready;
    assign bus.rd_valid      = rd_valid;
    assign bus.rd_data       = skid_head;
    assign bus.level         = count;
    assign bus.sram_addr_w   = wr_ptr;
    assign bus.sram_addr_r   = rd_ptr;
    assign bus.sram_write_en = wr_go;
    assign bus.sram_read_en  = rd_go;
    assign bus.sram_data_in  = bus.wr_data;

endmodule

// File: tb/tb_gbf_flgwei_fifo_ctrl.sv
// Bench for gbf_flgwei_fifo_ctrl: vector table, corner sequences and a queue-based reference model.
module tb_gbf_flgwei_fifo_ctrl;

    localparam int DB = 6;
    localparam int W  = 28;
    localparam int DEPTH = 1 << DB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    gbf_flgwei_fifo_ctrl_if #(.SRAM_DEPTH_BIT(DB), .SRAM_WIDTH(W)) bus();

    gbf_flgwei_fifo_ctrl #(
        .SRAM_DEPTH_BIT (DB),
        .SRAM_WIDTH     (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.master)
    );

    // Single-port SRAM with one-cycle registered read.
    logic [W-1:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (bus.sram_write_en) sram_mem[bus.sram_addr_w] <= bus.sram_data_in;
        if (bus.sram_read_en)  bus.sram_data_out <= sram_mem[bus.sram_addr_r];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: stored words as a queue, skid as a queue, one in-flight read.
    logic [W-1:0] mq[$];
    logic [W-1:0] msk[$];
    logic [W-1:0] outq[$];
    bit           mpend;
    logic [W-1:0] mpend_w;
    bit           mpri;
    int           mwp, mrp;

    task automatic model_clear();
        mq.delete();
        msk.delete();
        mpend = 0;
        mpend_w = '0;
        mpri = 1;
        mwp = 0;
        mrp = 0;
    endtask

    bit           s_wrdy, s_we, s_re, s_rv, s_wgo;
    logic [W-1:0] s_rd;
    int           s_lvl;

    // Called just after a falling edge; drives, samples, advances the model, waits one cycle.
    task automatic step(input bit wv, input logic [W-1:0] wd, input bit rr, input bit fl);
        bit want, full, wrdy, wgo, rgo, rv;
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        flush        = fl;
        #1;
        full = (mq.size() == DEPTH);
        want = (mq.size() != 0) && ((msk.size() + int'(mpend)) < 2);
        wrdy = !full && !(want && !mpri);
        wgo  = wv && wrdy && !fl;
        rgo  = want && !wgo && !fl;
        rv   = (msk.size() != 0);
        s_wrdy = bus.wr_ready; s_we = bus.sram_write_en; s_re = bus.sram_read_en;
        s_rv = bus.rd_valid; s_rd = bus.rd_data; s_lvl = int'(bus.level); s_wgo = wgo;
        chk("wr_ready", bus.wr_ready, wrdy);
        chk("rd_valid", bus.rd_valid, rv);
        chk("level", bus.level, mq.size());
        chk("sram_write_en", bus.sram_write_en, wgo);
        chk("sram_read_en", bus.sram_read_en, rgo);
        if (rv)  chk("rd_data", bus.rd_data, msk[0]);
        if (wgo) begin
            chk("sram_addr_w", bus.sram_addr_w, mwp);
            chk("sram_data_in", bus.sram_data_in, wd);
        end
        if (rgo) chk("sram_addr_r", bus.sram_addr_r, mrp);
        if (fl) begin
            model_clear();
        end else begin
            if (rv && rr) outq.push_back(msk.pop_front());
            if (mpend) msk.push_back(mpend_w);
            if (wv && want && !full) mpri = !mpri;
            if (wgo) begin
                mq.push_back(wd);
                mwp = (mwp + 1) % DEPTH;
            end
            mpend = rgo;
            if (rgo) begin
                mpend_w = mq.pop_front();
                mrp = (mrp + 1) % DEPTH;
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        bit           wv;
        logic [W-1:0] wd;
        bit           e_wrdy;
        bit           e_we;
        bit           e_re;
        int           e_lvl;
        bit           e_rv;
        logic [W-1:0] e_rd;
    } vec_t;

    vec_t vt [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int nxt;
        bit have;
        logic [W-1:0] cur;

        // Four writes with the consumer stalled: grants go W,W,R,W,R,W then the skid is full.
        vt[0] = '{1, 28'h1, 1, 1, 0, 0, 0, 28'h0};
        vt[1] = '{1, 28'h2, 1, 1, 0, 1, 0, 28'h0};
        vt[2] = '{1, 28'h3, 0, 0, 1, 2, 0, 28'h0};
        vt[3] = '{1, 28'h3, 1, 1, 0, 1, 0, 28'h0};
        vt[4] = '{1, 28'h4, 0, 0, 1, 2, 1, 28'h1};
        vt[5] = '{1, 28'h4, 1, 1, 0, 1, 1, 28'h1};
        vt[6] = '{0, 28'h0, 1, 0, 0, 2, 1, 28'h1};
        vt[7] = '{0, 28'h0, 1, 0, 0, 2, 1, 28'h1};

        bus.wr_valid = 0; bus.wr_data = '0; bus.rd_ready = 0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_level", bus.level, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_wr_ready", bus.wr_ready, 1);
        chk("rst_enables", {bus.sram_write_en, bus.sram_read_en}, 0);
        @(negedge clk);

        for (int unsigned i = 0; i < 8; i++) begin
            step(vt[i].wv, vt[i].wd, 0, 0);
            chk("vec_wr_ready", s_wrdy, vt[i].e_wrdy);
            chk("vec_write_en", s_we, vt[i].e_we);
            chk("vec_read_en", s_re, vt[i].e_re);
            chk("vec_level", s_lvl, vt[i].e_lvl);
            chk("vec_rd_valid", s_rv, vt[i].e_rv);
            if (vt[i].e_rv) chk("vec_rd_data", s_rd, vt[i].e_rd);
        end

        // Fill to capacity, then hold wr_valid against a full buffer.
        for (int unsigned i = 0; i < 80; i++) step(1, 28'h100 + i, 0, 0);
        step(1, 28'h123, 0, 0);
        chk("full_level", s_lvl, DEPTH);
        chk("full_wr_ready", s_wrdy, 0);
        chk("full_no_write", s_we, 0);

        guard = 0;
        while ((mq.size() != 0 || msk.size() != 0 || mpend) && guard < 300) begin
            step(0, '0, 1, 0);
            guard++;
        end
        step(0, '0, 1, 0);
        chk("drain_level", s_lvl, 0);
        chk("drain_rd_valid", s_rv, 0);

        // Single-word latency into an empty buffer.
        step(1, 28'hABCDEF1, 0, 0);
        chk("lat_t_write", s_we, 1);
        step(0, '0, 0, 0);
        chk("lat_t1_read_en", s_re, 1);
        step(0, '0, 0, 0);
        chk("lat_t2_rd_valid", s_rv, 0);
        step(0, '0, 0, 0);
        chk("lat_t3_rd_valid", s_rv, 1);
        chk("lat_t3_rd_data", s_rd, 28'hABCDEF1);
        step(0, '0, 1, 0);

        // Flush the cycle after a read issue, with a write also offered.
        step(1, 28'h00000AA, 0, 0);
        step(0, '0, 0, 0);
        chk("flush_pre_read_en", s_re, 1);
        step(1, 28'h00000BB, 0, 1);
        chk("flush_write_blocked", s_we, 0);
        chk("flush_read_blocked", s_re, 0);
        step(0, '0, 0, 0);
        chk("flush_rd_valid", s_rv, 0);
        chk("flush_level", s_lvl, 0);
        step(0, '0, 0, 0);
        chk("flush_no_push", s_rv, 0);

        // Random 200-word stream with random backpressure; order checked end to end.
        outq.delete();
        nxt = 1; have = 0; cur = '0;
        for (int unsigned cyc = 0; cyc < 4000 && outq.size() < 200; cyc++) begin
            if (!have && nxt <= 200 && $urandom_range(0, 3) != 0) begin
                cur = W'(nxt);
                have = 1;
            end
            step(have, cur, 1'($urandom_range(0, 1)), 0);
            if (have && s_wgo) begin
                have = 0;
                nxt++;
            end
        end
        chk("stream_count", outq.size(), 200);
        for (int unsigned i = 0; i < outq.size(); i++) chk("stream_order", outq[i], i + 1);

        // Asynchronous reset in the middle of traffic.
        for (int unsigned i = 0; i < 20; i++) step(1, 28'h500 + i, 1'($urandom_range(0, 1)), 0);
        bus.wr_valid = 0; bus.rd_ready = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", bus.level, 0);
        chk("arst_rd_valid", bus.rd_valid, 0);
        chk("arst_wr_ready", bus.wr_ready, 1);
        chk("arst_enables", {bus.sram_write_en, bus.sram_read_en}, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 6; i++) step(i < 2, 28'h600 + i, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
